// File: rtl/signed_minmax_tracker_if.sv
// signed_minmax_tracker_if: sample-in / frame-result-out handshake bundle
interface signed_minmax_tracker_if #(parameter int WIDTH = 4, parameter int CNT_W = 8);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_min;
  logic [WIDTH-1:0] out_max;
  logic [CNT_W-1:0] out_min_idx;
  logic [CNT_W-1:0] out_max_idx;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_min, out_max, out_min_idx, out_max_idx, out_count, out_ovf
  );
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_min, out_max, out_min_idx, out_max_idx, out_count, out_ovf
  );
endinterface

// File: rtl/signed_minmax_tracker.sv
// signed_minmax_tracker: running signed min/max with first-occurrence indices over a framed stream
module signed_minmax_tracker #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input logic                   clk,
  input logic                   rst,
  signed_minmax_tracker_if.slave s
);
  typedef enum logic {COLLECT, HOLD} state_t;
  state_t           state, state_nxt;
  logic             first;
  logic [WIDTH-1:0] min_q, max_q;
  logic [CNT_W-1:0] min_idx_q, max_idx_q, count_q;
  logic             ovf_q;
  logic             acc, sat, lt, gt;
  assign acc = s.in_valid && state == COLLECT;
  assign sat = &count_q;
  assign lt  = $signed(s.in_data) < $signed(min_q);
  assign gt  = $signed(s.in_data) > $signed(max_q);
  // frame ends on an accepted last sample; the result is released by out_ready
  always_comb begin
    state_nxt = state;
    if (state == COLLECT) state_nxt = (acc && s.in_last) ? HOLD : COLLECT;
    else state_nxt = s.out_ready ? COLLECT : HOLD;
  end
  // state register plus min/max/index/count tracking; saturated count doubles as the overflow index
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      first     <= 1'b1;
      min_q     <= '0;
      max_q     <= '0;
      min_idx_q <= '0;
      max_idx_q <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (acc && first) begin
        min_q     <= s.in_data;
        max_q     <= s.in_data;
        min_idx_q <= '0;
        max_idx_q <= '0;
        count_q   <= CNT_W'(1);
        first     <= 1'b0;
      end else if (acc) begin
        if (lt) begin
          min_q     <= s.in_data;
          min_idx_q <= count_q;
        end
        if (gt) begin
          max_q     <= s.in_data;
          max_idx_q <= count_q;
        end
        count_q <= sat ? count_q : count_q + CNT_W'(1);
        ovf_q   <= ovf_q | sat;
      end
      if (state == HOLD && s.out_ready) begin
        first   <= 1'b1;
        count_q <= '0;
        ovf_q   <= 1'b0;
      end
    end
  end
  assign s.in_ready    = state == COLLECT;
  assign s.out_valid   = state == HOLD;
  assign s.out_min     = min_q;
  assign s.out_max     = max_q;
  assign s.out_min_idx = min_idx_q;
  assign s.out_max_idx = max_idx_q;
  assign s.out_count   = count_q;
  assign s.out_ovf     = ovf_q;
endmodule
